// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Fetch-stage sequencer: imem handshake, PC enable, F/D register,
//            redirect squash of stale responses and sticky timeout error.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int N       = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] imem_addr_F,
    input  logic         PCSrc_F,
    input  logic         stall_D,
    input  logic         mem_ready,
    input  logic [31:0]  mem_rdata,
    output logic         pc_en_F,
    output logic         mem_req,
    output logic [N-1:0] mem_addr,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D,
    output logic         fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_DROP  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_pend;
    logic [N-1:0]   r_pend_addr;
    logic [7:0]     r_wait_cnt;
    logic           r_hold_vld;
    logic [31:0]    r_hold_instr;
    logic [N-1:0]   r_hold_pc;

    logic           w_issue;
    logic           w_done;
    logic           w_timeout;
    logic           w_fd_load;
    logic           w_fd_from_hold;
    logic           w_fd_clear;
    logic           w_hold_load;
    logic           w_hold_clr;

    // A new request goes out only when nothing is outstanding and F/D can take it.
    assign w_issue   = (r_state == S_FETCH) && !r_pend && (!valid_D || !stall_D);
    assign mem_req   = w_issue || (r_pend && ((r_state == S_FETCH) || (r_state == S_DROP)));
    assign mem_addr  = w_issue ? imem_addr_F : r_pend_addr;
    assign w_done    = mem_req && mem_ready;
    assign w_timeout = mem_req && !mem_ready && (r_wait_cnt == c_cnt_last);

    always_comb begin
        w_state_nxt    = r_state;
        pc_en_F        = 1'b0;
        w_fd_load      = 1'b0;
        w_fd_from_hold = 1'b0;
        w_fd_clear     = 1'b0;
        w_hold_load    = 1'b0;
        w_hold_clr     = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (PCSrc_F) begin
                    pc_en_F     = 1'b1;
                    w_fd_clear  = 1'b1;
                    w_hold_clr  = 1'b1;
                    w_state_nxt = (mem_req && !mem_ready) ? S_DROP : S_FETCH;
                end else if (w_done) begin
                    pc_en_F = 1'b1;
                    if (!stall_D) begin
                        w_fd_load = 1'b1;
                    end else begin
                        w_hold_load = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (!stall_D) begin
                    w_fd_clear = 1'b1;
                end
            end
            S_HOLD: begin
                if (PCSrc_F) begin
                    pc_en_F     = 1'b1;
                    w_fd_clear  = 1'b1;
                    w_hold_clr  = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (!stall_D) begin
                    w_fd_from_hold = 1'b1;
                    w_hold_clr     = 1'b1;
                    w_state_nxt    = S_FETCH;
                end
            end
            S_DROP: begin
                pc_en_F = PCSrc_F;
                if (mem_ready) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_ERR: w_state_nxt = S_ERR;
            default: w_state_nxt = S_IDLE;
        endcase
        // Timeout overrides everything: freeze the PC and kill F/D.
        if (w_timeout) begin
            w_state_nxt    = S_ERR;
            pc_en_F        = 1'b0;
            w_fd_load      = 1'b0;
            w_fd_from_hold = 1'b0;
            w_hold_load    = 1'b0;
            w_fd_clear     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pend       <= 1'b0;
            r_pend_addr  <= '0;
            r_wait_cnt   <= '0;
            r_hold_vld   <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            instr_D      <= '0;
            pc_D         <= '0;
            valid_D      <= 1'b0;
            fetch_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if ((w_state_nxt == S_ERR) || w_done) begin
                r_pend <= 1'b0;
            end else if (w_issue) begin
                r_pend <= 1'b1;
            end
            if (w_issue) begin
                r_pend_addr <= imem_addr_F;
            end

            if (w_done) begin
                r_wait_cnt <= '0;
            end else if (mem_req) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            if (w_fd_clear) begin
                valid_D <= 1'b0;
            end else if (w_fd_load) begin
                instr_D <= mem_rdata;
                pc_D    <= mem_addr;
                valid_D <= 1'b1;
            end else if (w_fd_from_hold) begin
                instr_D <= r_hold_instr;
                pc_D    <= r_hold_pc;
                valid_D <= r_hold_vld;
            end

            if (w_hold_load) begin
                r_hold_instr <= mem_rdata;
                r_hold_pc    <= mem_addr;
                r_hold_vld   <= 1'b1;
            end else if (w_hold_clr) begin
                r_hold_vld <= 1'b0;
            end

            if (w_state_nxt == S_ERR) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Scoreboard bench for fetch_ctrl with a latency-programmable imem
//            model and an external fetch PC register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    localparam int c_n = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [c_n-1:0] imem_addr_F;
    logic           PCSrc_F;
    logic           stall_D;
    logic           mem_ready;
    logic [31:0]    mem_rdata;
    logic           pc_en_F;
    logic           mem_req;
    logic [c_n-1:0] mem_addr;
    logic [31:0]    instr_D;
    logic [c_n-1:0] pc_D;
    logic           valid_D;
    logic           fetch_err;

    fetch_ctrl #(.TIMEOUT(8), .N(c_n)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr_F (imem_addr_F),
        .PCSrc_F     (PCSrc_F),
        .stall_D     (stall_D),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .pc_en_F     (pc_en_F),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .valid_D     (valid_D),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    int          last_pop_cyc;
    int          exp_gap;
    logic        prev_stall;
    int          mem_lat;
    logic        mem_off;
    int          wcnt;
    logic [63:0] branch_target;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0013;
    endfunction

    // Memory model: ready after mem_lat waiting cycles, or never when mem_off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      wcnt <= 0;
        else if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end
    assign mem_ready = mem_req && !mem_off && (wcnt >= mem_lat);
    assign mem_rdata = word_of(mem_addr);

    // External fetch PC register with branch mux.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        imem_addr_F <= '0;
        else if (pc_en_F) imem_addr_F <= PCSrc_F ? branch_target : imem_addr_F + 64'd4;
    end

    always_ff @(posedge clk) begin
        prev_stall <= stall_D;
        cyc        <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic push_exp(input logic [63:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = word_of(pc);
        sb_q.push_back(e);
    endtask

    // Monitor: F/D holds a fresh entry whenever valid_D is set and decode was not stalled.
    always @(negedge clk) begin
        if (!reset && valid_D && !prev_stall) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_fd_entry_pc", pc_D, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("fd_pc", pc_D, e.pc);
                chk("fd_instr", {32'd0, instr_D}, {32'd0, e.ins});
                if (exp_gap != 0 && last_pop_cyc >= 0)
                    chk("fd_gap", 64'(cyc - last_pop_cyc), 64'(exp_gap));
                last_pop_cyc = cyc;
            end
        end
    end

    task automatic cyc_step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mem_req"}, {63'd0, mem_req}, 64'd0);
        chk({tag, "_mem_addr"}, mem_addr, 64'd0);
        chk({tag, "_pc_D"}, pc_D, 64'd0);
        chk({tag, "_instr_D"}, {32'd0, instr_D}, 64'd0);
        chk({tag, "_valid_fe_pcen"}, {61'd0, valid_D, fetch_err, pc_en_F}, 64'd0);
    endtask

    task automatic start_reset(input int cycles, input int lat);
        reset   = 1'b1;
        stall_D = 1'b0;
        PCSrc_F = 1'b0;
        mem_lat = lat;
        repeat (cycles) cyc_step();
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            cyc_step();
            k++;
        end
        chk({name, "_drained"}, 64'(sb_q.size()), 64'd0);
        stall_D = 1'b1;
        exp_gap = 0;
    endtask

    task automatic wait_for(input string name, input logic [63:0] addr, input logic need_wait);
        int k = 0;
        while (!(mem_req && mem_addr == addr && (!need_wait || !mem_ready)) && k < 100) begin
            cyc_step();
            k++;
        end
        chk({name, "_reached"}, {63'd0, k < 100}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        prev_wait;
        logic [63:0] prev_addr;
        int          k;
        reset = 1'b1; stall_D = 1'b0; PCSrc_F = 1'b0;
        mem_lat = 0; mem_off = 1'b0; branch_target = '0;
        exp_gap = 0; last_pop_cyc = -1;

        // Zero-wait streaming after a 4-cycle reset.
        start_reset(4, 0);
        check_reset_vals("rst");
        push_exp(0); push_exp(4); push_exp(8); push_exp(12);
        reset = 1'b0;
        #1 chk("idle_bubble_pcen", {63'd0, pc_en_F}, 64'd0);
        exp_gap = 1;
        cyc_step();
        chk("first_fetch_bubble", {63'd0, valid_D}, 64'd0);
        chk("first_fetch_pcen", {63'd0, pc_en_F}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc_step();
            chk("stream_pcen", {63'd0, pc_en_F}, 64'd1);
        end
        drain("zero_wait");

        // Two wait cycles per request.
        start_reset(2, 2);
        push_exp(0); push_exp(4); push_exp(8);
        reset = 1'b0; exp_gap = 3; last_pop_cyc = -1;
        prev_wait = 1'b0; prev_addr = '0; k = 0;
        while (sb_q.size() != 0 && k < 60) begin
            cyc_step();
            if (prev_wait) chk("wait_addr_stable", mem_addr, prev_addr);
            if (mem_req && !mem_ready) chk("wait_pcen_low", {63'd0, pc_en_F}, 64'd0);
            if (mem_ready) chk("accept_pcen_high", {63'd0, pc_en_F}, 64'd1);
            prev_wait = mem_req && !mem_ready;
            prev_addr = mem_addr;
            k++;
        end
        drain("latency2");

        // Decode stall while pc_D=4 is live; request for 8 lands in HOLD.
        start_reset(2, 1);
        push_exp(0); push_exp(4); push_exp(8); push_exp(12);
        reset = 1'b0; last_pop_cyc = -1;
        k = 0;
        while (!(valid_D && pc_D == 64'd4) && k < 50) begin
            cyc_step();
            k++;
        end
        chk("stall_setup_reached", {63'd0, k < 50}, 64'd1);
        cyc_step();
        stall_D = 1'b1;
        #1 chk("stall_accept_pcen", {63'd0, pc_en_F}, 64'd1);
        chk("stall_pc_D_0", pc_D, 64'd4);
        cyc_step();
        chk("hold_no_req", {63'd0, mem_req}, 64'd0);
        chk("stall_pc_D_1", pc_D, 64'd4);
        chk("stall_instr_D", {32'd0, instr_D}, {32'd0, word_of(64'd4)});
        cyc_step();
        chk("stall_pc_D_2", pc_D, 64'd4);
        cyc_step();
        stall_D = 1'b0;
        drain("stall_hold");

        // Redirect to 0x80 while the request for 12 is waiting.
        start_reset(2, 3);
        push_exp(0); push_exp(4); push_exp(8); push_exp(64'h80);
        reset = 1'b0; last_pop_cyc = -1;
        wait_for("redir_req12", 64'd12, 1'b1);
        branch_target = 64'h80;
        PCSrc_F = 1'b1;
        #1 chk("redir_pcen", {63'd0, pc_en_F}, 64'd1);
        cyc_step();
        PCSrc_F = 1'b0;
        chk("redir_valid_cleared", {63'd0, valid_D}, 64'd0);
        chk("drop_keeps_old_addr", mem_addr, 64'd12);
        k = 0;
        while (!mem_ready && k < 20) begin
            cyc_step();
            k++;
        end
        chk("drop_discard_pcen", {63'd0, pc_en_F}, 64'd0);
        wait_for("redir_req80", 64'h80, 1'b0);
        drain("redirect");

        // Memory never answers: timeout after 8 request cycles.
        mem_off = 1'b1;
        start_reset(2, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc_step();
            chk("to_req_high", {62'd0, mem_req, fetch_err}, 64'd2);
        end
        cyc_step();
        chk("to_err_set", {61'd0, fetch_err, mem_req, pc_en_F}, 64'd4);
        chk("to_valid_low", {63'd0, valid_D}, 64'd0);
        repeat (3) cyc_step();
        chk("to_err_sticky", {62'd0, fetch_err, mem_req}, 64'd2);
        reset = 1'b1;
        #1 chk("to_err_cleared", {63'd0, fetch_err}, 64'd0);
        mem_off = 1'b0;

        // Asynchronous reset between edges while a request is waiting.
        start_reset(2, 3);
        push_exp(0); push_exp(4);
        reset = 1'b0; last_pop_cyc = -1;
        wait_for("async_req8", 64'd8, 1'b1);
        chk("async_pre_pc_D", pc_D, 64'd4);
        #3 reset = 1'b1;
        #1 check_reset_vals("async_rst");
        chk("async_q_empty", 64'(sb_q.size()), 64'd0);
        mem_lat = 0;
        repeat (2) cyc_step();
        push_exp(0); push_exp(4); push_exp(8);
        reset = 1'b0;
        drain("async_resume");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the pipelined fetch stage. It owns the instruction-memory request/ready handshake and gates the fetch PC register through pc_en_F.
- It places fetched instructions into the F/D pipeline register (instr_D, pc_D, valid_D) and honours decode stalls and taken-branch redirects (PCSrc_F, applied via the fetch PC mux).
- It discards responses to requests made stale by a redirect, and flags a sticky error on memory timeout.

Parameters:
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before error (2..255)
- N, 64, address/PC width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_addr_F  in  N  current PC from fetch PC register
- PCSrc_F  in  1  taken-branch redirect; fetch loads PCBranch_F when pc_en_F=1
- stall_D  in  1  decode cannot accept a new instruction this cycle
- mem_ready  in  1  memory response valid this cycle
- mem_rdata  in  32  instruction word, valid when mem_ready=1
- pc_en_F  out  1  enable for fetch PC register (combinational)
- mem_req  out  1  memory request
- mem_addr  out  N  request address
- instr_D  out  32  F/D instruction register
- pc_D  out  N  F/D PC register
- valid_D  out  1  F/D register holds a live instruction
- fetch_err  out  1  sticky timeout error

Behaviour:
- Reset (async, any state):
  - state=IDLE; mem_req=0; mem_addr=0; instr_D=0; pc_D=0; valid_D=0; fetch_err=0; wait counter=0; hold buffer invalid.
- States: IDLE, FETCH, HOLD, DROP, ERR.
- IDLE: no request. Moves to FETCH on the first edge after reset deasserts, giving one bubble cycle.
- FETCH, request issue:
  - If no request is pending and the slot is free (!valid_D || !stall_D), drive mem_req=1 and mem_addr=imem_addr_F, and latch that address as pending.
  - A pending request keeps mem_req=1 with the latched address, unchanged, until mem_ready. A request is never withdrawn except on error or reset.
- FETCH, accept (mem_ready=1, no redirect):
  - pc_en_F=1 that cycle, so the PC advances by 4 at the edge.
  - If stall_D=0: instr_D<=mem_rdata, pc_D<=mem_addr, valid_D<=1, and stay in FETCH.
  - If stall_D=1: capture into the hold buffer and go to HOLD.
  - Zero-wait memory (ready in the same cycle as req) sustains 1 instruction/cycle.
- FETCH, no accept: if stall_D=0, valid_D<=0 (bubble). If stall_D=1, the F/D contents hold.
- HOLD:
  - mem_req=0 and pc_en_F=0.
  - When stall_D=0: move the buffer into F/D (valid_D=1) and return to FETCH.
- Redirect (PCSrc_F=1, single cycle):
  - Has priority over stall_D and over accept.
  - pc_en_F=1, valid_D<=0, hold buffer discarded.
  - Outstanding request with mem_ready=0: go to DROP.
  - Request completing in the same cycle: response discarded, go to FETCH.
  - From HOLD or idle FETCH: go to FETCH.
- DROP:
  - mem_req=1 with the old address until mem_ready. The response is discarded (no F/D write, pc_en_F=0), then go to FETCH.
  - A further PCSrc_F in DROP sets pc_en_F=1 and stays in DROP.
- Timeout:
  - The counter increments each cycle mem_req=1 and mem_ready=0, and clears on accept.
  - When it reaches TIMEOUT: go to ERR.
- ERR: mem_req=0, pc_en_F=0, valid_D=0, fetch_err=1. Exit only by reset.
- pc_en_F=0 in every case not listed above, including mid-wait and stall.

Test Plan:
- Reset held 4 cycles, zero-wait memory, stall_D=0, PC starts at 0 -> outputs 0 during reset; IDLE bubble; then pc_D=0,4,8,12 on consecutive cycles with valid_D=1 and pc_en_F high each cycle.
- mem_ready delayed 2 cycles per request -> mem_addr stable while waiting; pc_D=0,4 arrive every 3 cycles; pc_en_F pulses only on accept.
- stall_D=1 for 3 cycles while pc_D=4 is valid -> instr_D/pc_D unchanged; at most one extra fetch (addr 8) held in HOLD; after release pc_D=8 then 12, with no loss or duplication.
- PCSrc_F=1 with target 0x80 while request for addr 12 is waiting -> valid_D=0; addr-12 response dropped; next request mem_addr=0x80; pc_D=0x80.
- TIMEOUT=8, mem_ready tied 0 -> fetch_err=1 after 8 request cycles; mem_req=0; state persists until reset, which clears fetch_err.
- Reset asserted mid-wait (asynchronously, between edges) -> all outputs return to reset values immediately; normal fetch resumes from PC 0.
